regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/cpu_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 68 ++++++
 rtl/regfile_sb.sv | 86 ++++++++
 tb/tb_regfile_sb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU-wide constants: default datapath/register-address widths and
// the index of the hard-wired zero register.
// No ports (package).
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Tracks which architectural registers have an outstanding producer
// (issued but not yet written back), plus a registered count of them.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   we, wa             write-back enable/address (clears the busy bit)
//   iss, iss_rd        issue enable/destination (sets the busy bit)
//   flush              clears every busy bit
//   busy               one bit per register, bit 0 always 0
//   busy_cnt           popcount of busy, registered
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic                    iss,
    input  logic [ADDR_W-1:0]       iss_rd,
    input  logic                    flush,
    output logic [(2**ADDR_W)-1:0]  busy,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_nxt;
    logic [ADDR_W:0]  cnt_nxt;

    // Next busy vector. The clear is applied before the set so that a new
    // producer issued in the same cycle as a write-back to the same register
    // keeps the register busy. Flush overrides both.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (we && (wa != ADDR_W'(ZERO_REG)))
                busy_nxt[wa] = 1'b0;
            if (iss && (iss_rd != ADDR_W'(ZERO_REG)))
                busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    // Count is recomputed from the next vector, so the registered count
    // always matches the registered busy bits.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end

    // Busy state and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Multi-read-port register file with a scoreboard of pending producers.
// Register 0 reads as zero, ignores writes and is never busy.
//
// Ports:
//   clk, rst     clock, async active-high reset
//   we, wa, wd   write-back port
//   ra           NUM_RD packed read addresses, port k = ra[k*ADDR_W +: ADDR_W]
//   rd           NUM_RD packed read data,      port k = rd[k*DATA_W +: DATA_W]
//   rbusy        per-port "read register has outstanding producer"
//   iss, iss_rd  issuing instruction and its destination register
//   flush        clears all pending marks
//   busy_cnt     number of registers currently busy
//
// Build option: define REGFILE_SB_BYPASS_EN to forward same-cycle
// write-back data to matching read ports (and report them not busy).
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     iss,
    input  logic [ADDR_W-1:0]        iss_rd,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Register array: whole array cleared on reset, register 0 never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (we && (wa != ADDR_W'(ZERO_REG))) begin
            regs[wa] <= wd;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .iss      (iss),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Read ports. Outputs are forced to zero during reset so that a bypassed
    // write-back value cannot leak out while the file is being cleared.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              hit;

        assign addr    = ra[k*ADDR_W +: ADDR_W];
        assign is_zero = (addr == ADDR_W'(ZERO_REG));
`ifdef REGFILE_SB_BYPASS_EN
        assign hit     = we && (wa == addr) && !is_zero;
`else
        assign hit     = 1'b0;
`endif
        assign rd[k*DATA_W +: DATA_W] = (rst || is_zero) ? '0 :
                                        hit              ? wd : regs[addr];
        assign rbusy[k] = !rst && !hit && busy[addr];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Directed testbench for regfile_sb with default parameters
// (DATA_W=32, ADDR_W=5, NUM_RD=2). Expectations follow the
// REGFILE_SB_BYPASS_EN setting of the build.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_sb dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .iss      (iss),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after
    // the rising edge, well away from it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic setRead(input logic [4:0] a0, input logic [4:0] a1);
        ra = {a1, a0};
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
        iss = 1'b0; iss_rd = '0; flush = 1'b0;
        #2;
        checkOutput("reset_rd",       rd,       64'h0);
        checkOutput("reset_rbusy",    rbusy,    64'h0);
        checkOutput("reset_busy_cnt", busy_cnt, 64'h0);
        applyStimulus();
        applyStimulus();
        rst = 1'b0;

        // Write r3, read it back next cycle
        we = 1'b1; wa = 5'd3; wd = 32'h0000_00AA;
        setRead(5'd3, 5'd0);
        checkOutput("r3_same_cycle", rd[31:0], BYPASS ? 64'hAA : 64'h0);
        applyStimulus();
        we = 1'b0;
        #1;
        checkOutput("r3_read", rd[31:0], 64'hAA);

        // Write to r0 is dropped
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
        applyStimulus();
        we = 1'b0;
        setRead(5'd3, 5'd0);
        checkOutput("r0_read",  rd[63:32], 64'h0);
        checkOutput("r0_rbusy", rbusy[1],  64'h0);

        // Issue to r5 then write it back
        iss = 1'b1; iss_rd = 5'd5;
        applyStimulus();
        iss = 1'b0;
        setRead(5'd5, 5'd0);
        checkOutput("r5_busy",     rbusy[0], 64'h1);
        checkOutput("r5_busy_cnt", busy_cnt, 64'h1);
        we = 1'b1; wa = 5'd5; wd = 32'h0000_1234;
        #1;
        checkOutput("r5_busy_wb_cycle", rbusy[0], BYPASS ? 64'h0 : 64'h1);
        applyStimulus();
        we = 1'b0;
        #1;
        checkOutput("r5_clear",     rbusy[0], 64'h0);
        checkOutput("r5_clear_cnt", busy_cnt, 64'h0);
        checkOutput("r5_data",      rd[31:0], 64'h1234);

        // Issue and write-back to r7 in the same cycle: producer wins
        iss = 1'b1; iss_rd = 5'd7;
        applyStimulus();
        checkOutput("r7_first_cnt", busy_cnt, 64'h1);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
        applyStimulus();
        iss = 1'b0; we = 1'b0;
        setRead(5'd7, 5'd0);
        checkOutput("r7_still_busy", rbusy[0], 64'h1);
        checkOutput("r7_cnt_same",   busy_cnt, 64'h1);
        checkOutput("r7_data",       rd[31:0], 64'h77);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0078;
        applyStimulus();
        we = 1'b0;
        #1;
        checkOutput("r7_cleared_cnt", busy_cnt, 64'h0);

        // Set r8 while clearing r6: net count unchanged
        iss = 1'b1; iss_rd = 5'd6;
        applyStimulus();
        iss_rd = 5'd8; we = 1'b1; wa = 5'd6; wd = 32'h0000_0066;
        applyStimulus();
        iss = 1'b0; we = 1'b0;
        setRead(5'd8, 5'd6);
        checkOutput("swap_cnt",     busy_cnt, 64'h1);
        checkOutput("swap_r8_busy", rbusy[0], 64'h1);
        checkOutput("swap_r6_free", rbusy[1], 64'h0);
        we = 1'b1; wa = 5'd8; wd = 32'h0000_0088;
        applyStimulus();
        we = 1'b0;
        #1;
        checkOutput("r8_cleared_cnt", busy_cnt, 64'h0);

        // Same-cycle read of r9 during its write-back
        we = 1'b1; wa = 5'd9; wd = 32'h0000_1111;
        applyStimulus();
        wd = 32'hDEAD_BEEF;
        setRead(5'd9, 5'd0);
        checkOutput("r9_bypass", rd[31:0], BYPASS ? 64'hDEAD_BEEF : 64'h1111);
        applyStimulus();
        we = 1'b0;
        #1;
        checkOutput("r9_after", rd[31:0], 64'hDEAD_BEEF);

        // Mark r1..r3 busy, then flush together with an issue to r4
        iss = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            iss_rd = 5'(i);
            applyStimulus();
        end
        iss = 1'b0;
        #1;
        checkOutput("three_busy_cnt", busy_cnt, 64'h3);
        flush = 1'b1; iss = 1'b1; iss_rd = 5'd4;
        we = 1'b1; wa = 5'd10; wd = 32'h0000_0055;
        applyStimulus();
        flush = 1'b0; iss = 1'b0; we = 1'b0;
        setRead(5'd4, 5'd10);
        checkOutput("flush_cnt",     busy_cnt, 64'h0);
        checkOutput("flush_r4_free", rbusy[0], 64'h0);
        checkOutput("flush_write",   rd[63:32], 64'h55);

        // Asynchronous reset between edges with two registers busy
        iss = 1'b1; iss_rd = 5'd11;
        applyStimulus();
        iss_rd = 5'd12;
        applyStimulus();
        iss = 1'b0;
        setRead(5'd3, 5'd11);
        checkOutput("pre_rst_cnt", busy_cnt, 64'h2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_cnt",   busy_cnt,  64'h0);
        checkOutput("async_rst_r3",    rd[31:0],  64'h0);
        checkOutput("async_rst_r11",   rd[63:32], 64'h0);
        checkOutput("async_rst_rbusy", rbusy,     64'h0);

        // No action on an edge while reset is held
        we = 1'b1; wa = 5'd13; wd = 32'h0000_0013;
        iss = 1'b1; iss_rd = 5'd13;
        applyStimulus();
        we = 1'b0; iss = 1'b0;
        rst = 1'b0;
        setRead(5'd13, 5'd0);
        checkOutput("rst_edge_cnt",   busy_cnt, 64'h0);
        checkOutput("rst_edge_data",  rd[31:0], 64'h0);
        checkOutput("rst_edge_rbusy", rbusy[0], 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
